// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one countdown timer between N_REQ requesters.
// Round-robin pick in IDLE, program the timer in SET, skip one ARM cycle so a
// stale expiry flag is not mistaken for the new one, then wait for expiry or
// cancel. All outputs are decoded from registered state only.
//
// Handshake: req[i] is a level held by requester i until done[i] pulses;
// dropping req[i] while it owns the timer in WAIT cancels the grant without a
// done pulse. set_timer is a one-cycle strobe qualified by timer_set_val.
module timer_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_delay,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [WIDTH-1:0]       timer_set_val,
   output logic                   set_timer,
   input  logic                   timer_is_high
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_ARM,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]   delay_q, delay_d;

   logic [WIDTH-1:0]   delay_arr [N_REQ];
   logic               found;
   logic [IDX_W-1:0]   pick;
   logic [IDX_W-1:0]   idx_next;

   // Unpack the flat delay bus into one word per requester.
   for (genvar g = 0; g < N_REQ; g++) begin : g_delay
      assign delay_arr[g] = req_delay[g*WIDTH +: WIDTH];
   end

   // Round-robin search: first requester at or after ptr, wrapping.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      found    = 1'b0;
      pick     = ptr_q;
      cand     = 0;
      cand_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found = 1'b1;
            pick  = cand_idx;
         end
      end
   end

   // Pointer value that follows the current owner (wraps to 0 at the end).
   assign idx_next = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

   // Next-state logic and registered-state output decode.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      delay_d   = delay_q;
      grant     = '0;
      done      = '0;
      set_timer = 1'b0;
      busy      = (state_q != S_IDLE);

      if (state_q != S_IDLE) begin
         grant[idx_q] = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (found) begin
               idx_d   = pick;
               delay_d = delay_arr[pick];
               state_d = S_SET;
            end
         end
         S_SET: begin
            set_timer = 1'b1;
            state_d   = S_ARM;
         end
         S_ARM: begin
            // Expiry flag may still reflect the previous load; ignore it.
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!req[idx_q]) begin
               ptr_d   = idx_next;
               state_d = S_IDLE;
            end else if (timer_is_high) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done[idx_q] = 1'b1;
            ptr_d       = idx_next;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // delay_q only changes on the IDLE->SET edge, so it is held until next SET.
   assign timer_set_val = delay_q;

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         delay_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         delay_q <= delay_d;
      end
   end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: table vectors, directed corner sequences and randomized
// traffic checked against a transaction-level reference model.
module tb_timer_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N*W-1:0]   req_delay;
   logic [N-1:0]     grant;
   logic [N-1:0]     done;
   logic             busy;
   logic [W-1:0]     timer_set_val;
   logic             set_timer;
   logic             timer_is_high;

   int errors = 0;
   int checks = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_delay     (req_delay),
      .grant         (grant),
      .done          (done),
      .busy          (busy),
      .timer_set_val (timer_set_val),
      .set_timer     (set_timer),
      .timer_is_high (timer_is_high)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // owner: requester holding the timer (-1 none); age: cycles since grant
   // (1 = program cycle, 2 = settle cycle, 3+ = waiting); fin: expiry cycle.
   int           m_owner = -1;
   int           m_age   = 0;
   int           m_ptr   = 0;
   bit           m_fin   = 1'b0;
   logic [W-1:0] m_val   = '0;

   task automatic model_step();
      int c;
      if (!rst) begin
         m_owner = -1; m_age = 0; m_ptr = 0; m_fin = 1'b0; m_val = '0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (m_owner < 0 && req[c]) begin
               m_owner = c;
               m_age   = 1;
               m_val   = req_delay[c*W +: W];
            end
         end
      end else if (m_fin) begin
         m_fin   = 1'b0;
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end else if (m_age < 3) begin
         m_age++;
      end else if (!req[m_owner]) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end else if (timer_is_high) begin
         m_fin = 1'b1;
      end
   endtask

   function automatic logic [N-1:0] onehot(int i);
      logic [N-1:0] one;
      one = 1;
      return (i >= 0) ? (one << i) : '0;
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input logic r, input logic [N-1:0] rq, input logic t);
      rst = r; req = rq; timer_is_high = t;
      tick();
   endtask

   task automatic expect5(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ed,
                          input logic eb, input logic es, input logic [W-1:0] ev);
      check({tag, ".grant"},   W'(grant), W'(eg));
      check({tag, ".done"},    W'(done),  W'(ed));
      check({tag, ".busy"},    W'(busy),  W'(eb));
      check({tag, ".set"},     W'(set_timer), W'(es));
      check({tag, ".val"},     timer_set_val, ev);
   endtask

   task automatic check_model(input int cyc);
      string tag;
      tag = $sformatf("rnd%0d", cyc);
      expect5(tag, onehot(m_owner), m_fin ? onehot(m_owner) : '0, m_owner >= 0,
              (m_owner >= 0) && (m_age == 1), m_val);
   endtask

   function automatic logic [N*W-1:0] dl(int d0, int d1, int d2, int d3);
      return {W'(d3), W'(d2), W'(d1), W'(d0)};
   endfunction

   function automatic int gidx(logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic           rst;
      logic [N-1:0]   req;
      logic           tih;
      logic [N*W-1:0] dly;
      logic [N-1:0]   eg;
      logic [N-1:0]   ed;
      logic           eb;
      logic           es;
      logic [W-1:0]   ev;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [N-1:0] rq, input logic t, input logic [N*W-1:0] d,
                      input logic [N-1:0] eg, input logic [N-1:0] ed, input logic eb,
                      input logic es, input logic [W-1:0] ev);
      vec_t v;
      v.rst = r; v.req = rq; v.tih = t; v.dly = d;
      v.eg = eg; v.ed = ed; v.eb = eb; v.es = es; v.ev = ev;
      tbl.push_back(v);
   endtask

   // ---------------- scoreboard for all-request rotation ----------------
   logic [W-1:0] exp_q[$];

   initial begin
      logic [N*W-1:0] d1, d1b;
      int             ngr, ndn, gi;
      rst = 1'b0; req = '0; timer_is_high = 1'b0; req_delay = '0;
      d1  = dl(10, 5, 0, 7);
      d1b = dl(99, 6, 0, 8);

      // reset, single request with late expiry, two-way rotation, cancel
      add(0, 4'b0000, 0, d1,  4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0000, 0, d1,  4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b0001, 0, d1,  4'b0001, 4'b0000, 1, 1, 10);
      add(1, 4'b0001, 0, d1b, 4'b0001, 4'b0000, 1, 0, 10);
      add(1, 4'b0001, 0, d1b, 4'b0001, 4'b0000, 1, 0, 10);
      for (int i = 0; i < 5; i++)
         add(1, 4'b0001, 0, d1b, 4'b0001, 4'b0000, 1, 0, 10);
      add(1, 4'b0001, 1, d1,  4'b0001, 4'b0001, 1, 0, 10);
      add(1, 4'b0000, 0, d1,  4'b0000, 4'b0000, 0, 0, 10);
      add(0, 4'b0000, 0, d1,  4'b0000, 4'b0000, 0, 0, 0);
      add(1, 4'b1010, 0, d1,  4'b0010, 4'b0000, 1, 1, 5);
      add(1, 4'b1010, 0, d1b, 4'b0010, 4'b0000, 1, 0, 5);
      add(1, 4'b1010, 1, d1b, 4'b0010, 4'b0000, 1, 0, 5);
      add(1, 4'b1010, 1, d1b, 4'b0010, 4'b0010, 1, 0, 5);
      add(1, 4'b1000, 0, d1,  4'b0000, 4'b0000, 0, 0, 5);
      add(1, 4'b1000, 0, d1,  4'b1000, 4'b0000, 1, 1, 7);
      add(1, 4'b1000, 0, d1,  4'b1000, 4'b0000, 1, 0, 7);
      add(1, 4'b1000, 0, d1,  4'b1000, 4'b0000, 1, 0, 7);
      add(1, 4'b1000, 1, d1,  4'b1000, 4'b1000, 1, 0, 7);
      add(1, 4'b0000, 0, d1,  4'b0000, 4'b0000, 0, 0, 7);
      add(1, 4'b0011, 0, d1,  4'b0001, 4'b0000, 1, 1, 10);
      add(1, 4'b0011, 0, d1,  4'b0001, 4'b0000, 1, 0, 10);
      add(1, 4'b0011, 0, d1,  4'b0001, 4'b0000, 1, 0, 10);
      add(1, 4'b0010, 1, d1,  4'b0000, 4'b0000, 0, 0, 10);
      add(1, 4'b0010, 0, d1,  4'b0010, 4'b0000, 1, 1, 5);
      add(0, 4'b0000, 0, d1,  4'b0000, 4'b0000, 0, 0, 0);

      foreach (tbl[i]) begin
         rst = tbl[i].rst; req = tbl[i].req; timer_is_high = tbl[i].tih;
         req_delay = tbl[i].dly;
         tick();
         expect5($sformatf("vec%0d", i), tbl[i].eg, tbl[i].ed, tbl[i].eb, tbl[i].es, tbl[i].ev);
      end

      // all four held, expiry always high: rotation 0,1,2,3,0
      req_delay = dl(1, 2, 3, 4);
      drive(0, 4'b0000, 0);
      exp_q = '{0, 1, 2, 3, 0};
      ngr = 0; ndn = 0;
      for (int c = 0; c < 60 && ndn < 5; c++) begin
         drive(1, 4'b1111, 1);
         check("rot.onehot", W'($onehot0(grant)), 1);
         if (set_timer) begin
            gi = gidx(grant);
            ngr++;
            if (exp_q.size() == 0) check("rot.extra_grant", W'(gi), '1);
            else check("rot.order", W'(gi), exp_q.pop_front());
            check("rot.val", timer_set_val, W'(gi + 1));
         end
         if (done != '0) begin
            ndn++;
            check("rot.done_owner", W'(done), W'(grant));
         end
      end
      check("rot.grants", W'(ngr), 5);
      check("rot.dones", W'(ndn), 5);
      drive(1, 4'b0000, 0);

      // cancel of req[2] with simultaneous expiry; ptr moves to 3
      req_delay = d1;
      drive(0, 4'b0000, 0);
      drive(1, 4'b0100, 0);
      expect5("cxl.set", 4'b0100, 4'b0000, 1, 1, 0);
      drive(1, 4'b0100, 0);
      drive(1, 4'b0100, 0);
      expect5("cxl.wait", 4'b0100, 4'b0000, 1, 0, 0);
      drive(1, 4'b0000, 1);
      expect5("cxl.idle", 4'b0000, 4'b0000, 0, 0, 0);
      drive(1, 4'b1001, 0);
      expect5("cxl.ptr3", 4'b1000, 4'b0000, 1, 1, 7);

      // reset while waiting with grant[1], then restart
      drive(0, 4'b0000, 0);
      drive(1, 4'b0010, 0);
      drive(1, 4'b0010, 0);
      drive(1, 4'b0010, 0);
      expect5("rst.wait", 4'b0010, 4'b0000, 1, 0, 5);
      drive(0, 4'b0010, 1);
      expect5("rst.abort", 4'b0000, 4'b0000, 0, 0, 0);
      drive(1, 4'b0010, 0);
      expect5("rst.restart", 4'b0010, 4'b0000, 1, 1, 5);

      // stale expiry flag high before the request must not finish it
      req_delay = dl(50, 1, 1, 1);
      drive(0, 4'b0000, 1);
      drive(1, 4'b0000, 1);
      expect5("stale.idle", 4'b0000, 4'b0000, 0, 0, 0);
      drive(1, 4'b0001, 1);
      expect5("stale.set", 4'b0001, 4'b0000, 1, 1, 50);
      drive(1, 4'b0001, 1);
      drive(1, 4'b0001, 1);
      expect5("stale.wait", 4'b0001, 4'b0000, 1, 0, 50);
      for (int i = 0; i < 3; i++) begin
         drive(1, 4'b0001, 0);
         expect5("stale.hold", 4'b0001, 4'b0000, 1, 0, 50);
      end
      drive(1, 4'b0001, 1);
      expect5("stale.done", 4'b0001, 4'b0001, 1, 0, 50);

      // randomized traffic against the reference model
      drive(0, 4'b0000, 0);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 199) != 0);
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               if (m_fin && m_owner == i) req[i] = 1'($urandom_range(0, 1));
               else if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
            end
            req_delay[i*W +: W] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom());
         end
         timer_is_high = ($urandom_range(0, 3) == 0);
         tick();
         check_model(cyc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
